// File: rtl/vdp_vga_timing.sv
// VDP raster timing: 640x480@60 VGA counters, syncs and blank, plus the
// SMS line timebase, V counter, status flags and Z80 interrupt line.
//
// Ports:
//   clk, rst_L          pixel clock, async active-low reset
//   R0, R1, R10         mode regs (IE1 = R0[4], IE0 = R1[5]), line reload
//   status_rd           CPU read of control port (clears flags after cycle)
//   spr_ovf_set/col_set sprite overflow / collision events
//   col, row            raster counters
//   hsync_L, vsync_L    active-low syncs
//   vga_blank           high outside the visible area
//   vcount              SMS V counter
//   status              {F, OVF, COL, 5'b0}
//   line_start          pulse on the first cycle of each SMS line
//   irq_L               active-low Z80 interrupt
module vdp_vga_timing #(
    parameter int H_VISIBLE    = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_VISIBLE    = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int ACTIVE_TOP   = 48,
    parameter int ACTIVE_LINES = 192
) (
    input  logic       clk,
    input  logic       rst_L,
    input  logic [7:0] R0,
    input  logic [7:0] R1,
    input  logic [7:0] R10,
    input  logic       status_rd,
    input  logic       spr_ovf_set,
    input  logic       spr_col_set,
    output logic [9:0] col,
    output logic [9:0] row,
    output logic       hsync_L,
    output logic       vsync_L,
    output logic       vga_blank,
    output logic [7:0] vcount,
    output logic [7:0] status,
    output logic       line_start,
    output logic       irq_L
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_VIS   = 10'(H_VISIBLE);
    localparam logic [9:0]  V_VIS   = 10'(V_VISIBLE);
    localparam logic [9:0]  HS_BEG  = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0]  HS_END  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  VS_BEG  = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0]  VS_END  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic [10:0] V_TOT11 = 11'(V_TOTAL);
    localparam logic [10:0] V_OFS   = 11'(V_TOTAL - ACTIVE_TOP);
    localparam logic [8:0]  F_LINE  = 9'(ACTIVE_LINES);
    // NTSC SMS frame: 262 lines, V counter jumps back by 6 after 0xDA
    localparam logic [8:0]  SMS_LAST = 9'd261;
    localparam logic [8:0]  VC_SPLIT = 9'd218;

    logic [9:0] col_q, col_d;
    logic [9:0] row_q, row_d;
    logic       f_q, f_d;
    logic       ovf_q, ovf_d;
    logic       cf_q, cf_d;
    logic       lf_q, lf_d;
    logic [7:0] lcnt_q, lcnt_d;

    logic [10:0] vsum;
    logic [10:0] vwrap;
    logic [9:0]  vline;
    logic [8:0]  sms;
    logic [8:0]  sms_m6;
    logic        ls;
    logic        lf_hit;

    // Raster counters
    always_comb begin
        col_d = col_q + 10'd1;
        row_d = row_q;
        if (col_q == H_LAST) begin
            col_d = '0;
            row_d = (row_q == V_LAST) ? '0 : row_q + 10'd1;
        end
    end

    // SMS line timebase: VGA rows relative to active top, two rows per line
    assign vsum   = {1'b0, row_q} + V_OFS;
    assign vwrap  = vsum - V_TOT11;
    assign vline  = (vsum >= V_TOT11) ? vwrap[9:0] : vsum[9:0];
    assign sms    = (vline[9:1] > SMS_LAST) ? SMS_LAST : vline[9:1];
    assign sms_m6 = sms - 9'd6;
    assign ls     = (col_q == '0) && !vline[0] && (vline < V_LAST);

    // Line interrupt counter and flag updates; a set beats a read-clear
    always_comb begin
        lcnt_d = lcnt_q;
        lf_hit = 1'b0;
        if (ls) begin
            if (sms <= F_LINE) begin
                if (lcnt_q == 8'd0) begin
                    lcnt_d = R10;
                    lf_hit = 1'b1;
                end else begin
                    lcnt_d = lcnt_q - 8'd1;
                end
            end else begin
                lcnt_d = R10;
            end
        end
        f_d   = (f_q & ~status_rd) | (ls & (sms == F_LINE));
        ovf_d = (ovf_q & ~status_rd) | spr_ovf_set;
        cf_d  = (cf_q & ~status_rd) | spr_col_set;
        lf_d  = (lf_q & ~status_rd) | lf_hit;
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            col_q  <= '0;
            row_q  <= '0;
            f_q    <= 1'b0;
            ovf_q  <= 1'b0;
            cf_q   <= 1'b0;
            lf_q   <= 1'b0;
            lcnt_q <= 8'hFF;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            f_q    <= f_d;
            ovf_q  <= ovf_d;
            cf_q   <= cf_d;
            lf_q   <= lf_d;
            lcnt_q <= lcnt_d;
        end
    end

    assign col        = col_q;
    assign row        = row_q;
    assign hsync_L    = !((col_q >= HS_BEG) && (col_q <= HS_END));
    assign vsync_L    = !((row_q >= VS_BEG) && (row_q <= VS_END));
    assign vga_blank  = (col_q >= H_VIS) || (row_q >= V_VIS);
    assign vcount     = (sms <= VC_SPLIT) ? sms[7:0] : sms_m6[7:0];
    assign line_start = ls;
    assign status     = {f_q, ovf_q, cf_q, 5'b0};
    assign irq_L      = ~((f_q & R1[5]) | (lf_q & R0[4]));

    logic unused_bits;
    assign unused_bits = ^{R0[7:5], R0[3:0], R1[7:6], R1[4:0],
                           vwrap[10], sms_m6[8]};

endmodule

// File: tb/tb_vdp_vga_timing.sv
// Bench for vdp_vga_timing: randomized mode/event stimulus against an
// arithmetic model of the raster and flag rules; two DUT geometries.
`timescale 1ns/1ps
module tb_vdp_vga_timing;

    // Narrow-line instance so whole frames fit in a short run
    localparam int HV = 32;
    localparam int HF = 2;
    localparam int HS = 4;
    localparam int HB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = 525;
    localparam int FT = 800;
    localparam int N_CYC   = 48000;
    localparam int RST_CYC = 33000;
    localparam int QUIET   = 17000;

    logic       clk = 1'b0;
    logic       rst_L = 1'b0;
    logic [7:0] R0, R1, R10;
    logic       status_rd, spr_ovf_set, spr_col_set;

    logic [9:0] col, row;
    logic       hsync_L, vsync_L, vga_blank, line_start, irq_L;
    logic [7:0] vcount, status;

    logic [9:0] col_f, row_f;
    logic       hsync_f, vsync_f, blank_f, ls_f, irq_f;
    logic [7:0] vcount_f, status_f;

    always #20 clk = ~clk;

    vdp_vga_timing #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB)
    ) dut (
        .clk(clk), .rst_L(rst_L), .R0(R0), .R1(R1), .R10(R10),
        .status_rd(status_rd), .spr_ovf_set(spr_ovf_set),
        .spr_col_set(spr_col_set), .col(col), .row(row),
        .hsync_L(hsync_L), .vsync_L(vsync_L), .vga_blank(vga_blank),
        .vcount(vcount), .status(status), .line_start(line_start),
        .irq_L(irq_L)
    );

    vdp_vga_timing dut_full (
        .clk(clk), .rst_L(rst_L), .R0(8'h00), .R1(8'h00), .R10(8'h00),
        .status_rd(1'b0), .spr_ovf_set(1'b0), .spr_col_set(1'b0),
        .col(col_f), .row(row_f), .hsync_L(hsync_f), .vsync_L(vsync_f),
        .vga_blank(blank_f), .vcount(vcount_f), .status(status_f),
        .line_start(ls_f), .irq_L(irq_f)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int t, tf, ls_cnt, mlc;
    bit mf, mo, mc, ml;

    function automatic int vl_of(int r);
        return (r + VT - 48) % VT;
    endfunction

    function automatic int sms_of(int r);
        int h;
        h = vl_of(r) / 2;
        return (h > 261) ? 261 : h;
    endfunction

    function automatic int vc_of(int r);
        int s;
        s = sms_of(r);
        return (s <= 218) ? s : ((s - 6) & 255);
    endfunction

    function automatic bit ls_of(int c, int r);
        return (c == 0) && (vl_of(r) % 2 == 0) && (vl_of(r) < 524);
    endfunction

    task automatic model_reset();
        t = 0; tf = 0;
        mf = 0; mo = 0; mc = 0; ml = 0;
        mlc = 255;
    endtask

    task automatic model_step();
        int c, r, s;
        bit lsv, lhit, fhit;
        c = t % HT;
        r = (t / HT) % VT;
        s = sms_of(r);
        lsv = ls_of(c, r);
        lhit = 0;
        fhit = 0;
        if (lsv) begin
            if (t < HT * VT) ls_cnt++;
            if (s <= 192) begin
                if (mlc == 0) begin
                    mlc = R10;
                    lhit = 1;
                end else begin
                    mlc = mlc - 1;
                end
            end else begin
                mlc = R10;
            end
            if (s == 192) fhit = 1;
        end
        mf = fhit | (mf & !status_rd);
        mo = spr_ovf_set | (mo & !status_rd);
        mc = spr_col_set | (mc & !status_rd);
        ml = lhit | (ml & !status_rd);
        t++;
        tf++;
    endtask

    task automatic check_all();
        int c, r, cf, rf;
        c = t % HT;
        r = (t / HT) % VT;
        chk("col", col, c);
        chk("row", row, r);
        chk("hsync", hsync_L, !(c >= HV + HF && c < HV + HF + HS));
        chk("vsync", vsync_L, !(r >= 490 && r <= 491));
        chk("blank", vga_blank, (c >= HV) || (r >= 480));
        chk("vcount", vcount, vc_of(r));
        chk("line_start", line_start, ls_of(c, r));
        chk("status", status, {24'b0, mf, mo, mc, 5'b0});
        chk("irq", irq_L, !((mf && R1[5]) || (ml && R0[4])));
        cf = tf % FT;
        rf = (tf / FT) % VT;
        chk("full_col", col_f, cf);
        chk("full_row", row_f, rf);
        chk("full_hsync", hsync_f, !(cf >= 656 && cf <= 751));
        chk("full_vsync", vsync_f, !(rf >= 490 && rf <= 491));
        chk("full_blank", blank_f, (cf >= 640) || (rf >= 480));
        chk("full_vcount", vcount_f, vc_of(rf));
        chk("full_ls", ls_f, ls_of(cf, rf));
        chk("full_status", status_f, 0);
        chk("full_irq", irq_f, 1);
    endtask

    task automatic drive(input int cyc);
        bit quiet;
        quiet = (cyc >= QUIET) && (cyc < RST_CYC);
        status_rd = !quiet && ($urandom_range(1499, 0) == 0);
        spr_ovf_set = ($urandom_range(1999, 0) == 0);
        spr_col_set = ($urandom_range(1999, 0) == 0);
        if ($urandom_range(4999, 0) == 0) R1[5] = ~R1[5];
        if ($urandom_range(4999, 0) == 0) R0[4] = ~R0[4];
        if ($urandom_range(2999, 0) == 0) R10 = 8'($urandom_range(7, 0));
        if (cyc == 1000) begin
            spr_col_set = 1'b1;
            status_rd = 1'b1;
        end
        if (cyc == 1001) begin
            spr_col_set = 1'b0;
            status_rd = 1'b0;
        end
        if (cyc == 1002) begin
            spr_col_set = 1'b0;
            status_rd = 1'b1;
        end
    endtask

    initial begin
        R0 = 8'h10;
        R1 = 8'h20;
        R10 = 8'd3;
        status_rd = 1'b0;
        spr_ovf_set = 1'b0;
        spr_col_set = 1'b0;
        ls_cnt = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        chk("rst_vcount", vcount, 8'hE8);
        rst_L = 1'b1;
        drive(0);
        model_step();
        for (int cyc = 1; cyc < N_CYC; cyc++) begin
            @(negedge clk);
            check_all();
            if (cyc == HT * VT) chk("ls_per_frame", ls_cnt, 262);
            if (cyc == RST_CYC) begin
                chk("pre_rst_F", status[7], mf);
                #2 rst_L = 1'b0;
                #1;
                chk("arst_col", col, 0);
                chk("arst_row", row, 0);
                chk("arst_status", status, 0);
                chk("arst_irq", irq_L, 1);
                chk("arst_vcount", vcount, 8'hE8);
                chk("arst_full_col", col_f, 0);
                model_reset();
                @(negedge clk);
                check_all();
                rst_L = 1'b1;
            end
            drive(cyc);
            model_step();
        end
        @(negedge clk);
        check_all();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
